// File: rtl/mm_pkg.sv
// rtl/mm_pkg.sv - shared register map, status bits, FSM states and strobe merge for the matmul controller
package mm_pkg;

  localparam logic [11:0] CTRL_OFF   = 12'h000;
  localparam logic [11:0] STATUS_OFF = 12'h004;
  localparam logic [11:0] ROW_A_BASE = 12'h100;
  localparam logic [11:0] MAT_B_BASE = 12'h200;
  localparam logic [11:0] ROW_C_BASE = 12'h800;

  localparam int STAT_BUSY = 0;
  localparam int STAT_DONE = 1;
  localparam int STAT_ERR  = 2;

  localparam int CTRL_START      = 0;
  localparam int CTRL_CLEAR_DONE = 1;
  localparam int CTRL_CLEAR_ERR  = 2;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  function automatic logic [31:0] merge_wstrb(input logic [31:0] old_word,
                                               input logic [31:0] new_word,
                                               input logic [3:0]  wstrb);
    logic [31:0] r;
    r = old_word;
    for (int b = 0; b < 4; b++) begin
      if (wstrb[b]) r[b*8 +: 8] = new_word[b*8 +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/mm_bus_if.sv
// rtl/mm_bus_if.sv - PicoRV32-style native memory bus slice plus window select
interface mm_bus_if;
  logic        sel;
  logic        mem_valid;
  logic        mem_ready;
  logic [11:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;

  modport master (output sel, mem_valid, mem_addr, mem_wdata, mem_wstrb,
                  input  mem_ready, mem_rdata);
  modport slave  (input  sel, mem_valid, mem_addr, mem_wdata, mem_wstrb,
                  output mem_ready, mem_rdata);
endinterface

// File: rtl/mm_bus_slave.sv
// rtl/mm_bus_slave.sv - request accept, one-cycle ready, registered read data, byte-strobe merge
module mm_bus_slave
  import mm_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  mm_bus_if.slave     bus,
  input  logic [31:0] cur_word,
  output logic        wr_en,
  output logic [31:0] wr_word
);

  logic accept;

  // Ready being high blocks a new accept, so each request takes exactly two cycles.
  assign accept  = bus.sel & bus.mem_valid & ~bus.mem_ready;
  assign wr_en   = accept & (|bus.mem_wstrb);
  assign wr_word = merge_wstrb(cur_word, bus.mem_wdata, bus.mem_wstrb);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bus.mem_ready <= 1'b0;
      bus.mem_rdata <= '0;
    end else begin
      bus.mem_ready <= accept;
      bus.mem_rdata <= (accept && bus.mem_wstrb == 4'b0000) ? cur_word : 32'h0;
    end
  end

endmodule

// File: rtl/mm_acc_ctrl.sv
// rtl/mm_acc_ctrl.sv - operand/result registers and start/settle/capture sequencing for the matmul accelerator
module mm_acc_ctrl
  import mm_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int CHUNK_WIDTH  = 8,
  parameter int CHUNK_HEIGHT = 8,
  parameter int ACC_LATENCY  = 2
) (
  input  logic                                           clk,
  input  logic                                           resetn,
  mm_bus_if.slave                                        bus,
  output logic [CHUNK_WIDTH*DATA_WIDTH-1:0]              acc_row_a,
  output logic [CHUNK_WIDTH*CHUNK_HEIGHT*DATA_WIDTH-1:0] acc_matrix_b,
  input  logic [CHUNK_WIDTH*2*DATA_WIDTH-1:0]            acc_row_c,
  output logic                                           irq
);

  localparam int NB    = CHUNK_WIDTH * CHUNK_HEIGHT;
  localparam int CNT_W = $clog2(ACC_LATENCY) + 1;
  localparam logic [9:0] CTRL_W   = CTRL_OFF[11:2];
  localparam logic [9:0] STATUS_W = STATUS_OFF[11:2];
  localparam logic [9:0] ROW_A_W  = ROW_A_BASE[11:2];
  localparam logic [9:0] MAT_B_W  = MAT_B_BASE[11:2];
  localparam logic [9:0] ROW_C_W  = ROW_C_BASE[11:2];

  logic [DATA_WIDTH-1:0]   row_a [CHUNK_WIDTH];
  logic [DATA_WIDTH-1:0]   mat_b [NB];
  logic [2*DATA_WIDTH-1:0] row_c [CHUNK_WIDTH];
  logic [0:0]              state;
  logic [CNT_W-1:0]        cnt;
  logic                    done, err, busy, capture;
  logic                    wr_en, ctrl_wr, start, clr_done, clr_err, op_hit;
  logic [31:0]             cur_word, wr_word;
  logic [9:0]              word;
  logic                    unused_addr;

  assign word        = bus.mem_addr[11:2];
  assign unused_addr = ^bus.mem_addr[1:0];
  assign busy        = (state == ST_RUN);
  assign capture     = busy && (cnt == '0);
  assign irq         = done;

  mm_bus_slave u_slave (
    .clk     (clk),
    .resetn  (resetn),
    .bus     (bus),
    .cur_word(cur_word),
    .wr_en   (wr_en),
    .wr_word (wr_word)
  );

  assign ctrl_wr  = wr_en & (word == CTRL_W) & bus.mem_wstrb[0];
  assign start    = ctrl_wr & bus.mem_wdata[CTRL_START];
  assign clr_done = ctrl_wr & bus.mem_wdata[CTRL_CLEAR_DONE];
  assign clr_err  = ctrl_wr & bus.mem_wdata[CTRL_CLEAR_ERR];
  assign op_hit   = ((word >= ROW_A_W) && (word < ROW_A_W + 10'(CHUNK_WIDTH))) ||
                    ((word >= MAT_B_W) && (word < MAT_B_W + 10'(NB)));

  always_comb begin
    cur_word = '0;
    if (word == STATUS_W) begin
      cur_word[STAT_BUSY] = busy;
      cur_word[STAT_DONE] = done;
      cur_word[STAT_ERR]  = err;
    end
    for (int i = 0; i < CHUNK_WIDTH; i++) begin
      if (word == ROW_A_W + 10'(i)) cur_word = row_a[i];
      if (word == ROW_C_W + 10'(2*i)) cur_word = row_c[i][DATA_WIDTH-1:0];
      if (word == ROW_C_W + 10'(2*i+1)) cur_word = row_c[i][2*DATA_WIDTH-1:DATA_WIDTH];
    end
    for (int k = 0; k < NB; k++) begin
      if (word == MAT_B_W + 10'(k)) cur_word = mat_b[k];
    end
  end

  // Operands stay frozen while the accelerator settles.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < CHUNK_WIDTH; i++) row_a[i] <= '0;
      for (int k = 0; k < NB; k++) mat_b[k] <= '0;
      for (int i = 0; i < CHUNK_WIDTH; i++) row_c[i] <= '0;
    end else begin
      for (int i = 0; i < CHUNK_WIDTH; i++) begin
        if (wr_en && !busy && word == ROW_A_W + 10'(i)) row_a[i] <= wr_word;
        if (capture) row_c[i] <= acc_row_c[i*2*DATA_WIDTH +: 2*DATA_WIDTH];
      end
      for (int k = 0; k < NB; k++) begin
        if (wr_en && !busy && word == MAT_B_W + 10'(k)) mat_b[k] <= wr_word;
      end
    end
  end

  // Later assignments win: error set over clear, capture's done over CLEAR_DONE.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= ST_IDLE;
      cnt   <= '0;
      done  <= 1'b0;
      err   <= 1'b0;
    end else begin
      if (clr_err) err <= 1'b0;
      if (busy && (start || (wr_en && op_hit))) err <= 1'b1;
      if (clr_done) done <= 1'b0;
      if (state == ST_IDLE) begin
        if (start) begin
          state <= ST_RUN;
          cnt   <= CNT_W'(ACC_LATENCY - 1);
          done  <= 1'b0;
        end
      end else if (cnt == '0) begin
        state <= ST_IDLE;
        done  <= 1'b1;
      end else begin
        cnt <= cnt - 1'b1;
      end
    end
  end

  for (genvar i = 0; i < CHUNK_WIDTH; i++) begin : g_row_a
    assign acc_row_a[i*DATA_WIDTH +: DATA_WIDTH] = row_a[i];
  end
  for (genvar k = 0; k < NB; k++) begin : g_mat_b
    assign acc_matrix_b[k*DATA_WIDTH +: DATA_WIDTH] = mat_b[k];
  end

endmodule

// File: tb/tb_mm_acc_ctrl.sv
// tb/tb_mm_acc_ctrl.sv - self-checking bench for mm_acc_ctrl with transaction-level reference model
module tb_mm_acc_ctrl;

  localparam int DW  = 32;
  localparam int CW  = 8;
  localparam int CH  = 8;
  localparam int LAT = 4;

  logic clk = 1'b0;
  logic resetn = 1'b1;
  mm_bus_if bus();
  logic [CW*DW-1:0]    acc_row_a;
  logic [CW*CH*DW-1:0] acc_matrix_b;
  logic [CW*2*DW-1:0]  acc_row_c;
  logic                irq;
  logic [63:0]         acc_sum;

  int n_chk = 0;
  int n_pass = 0;
  int n_fail = 0;

  mm_acc_ctrl #(.DATA_WIDTH(DW), .CHUNK_WIDTH(CW), .CHUNK_HEIGHT(CH), .ACC_LATENCY(LAT)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .bus         (bus),
    .acc_row_a   (acc_row_a),
    .acc_matrix_b(acc_matrix_b),
    .acc_row_c   (acc_row_c),
    .irq         (irq)
  );

  always #5 clk = ~clk;

  // Unsigned combinational accelerator: C[j] = sum_i A[i] * B[i][j]
  always_comb begin
    acc_row_c = '0;
    acc_sum   = '0;
    for (int j = 0; j < CH; j++) begin
      acc_sum = '0;
      for (int i = 0; i < CW; i++)
        acc_sum = acc_sum + 64'(acc_row_a[i*DW +: DW]) * 64'(acc_matrix_b[(i*CH+j)*DW +: DW]);
      acc_row_c[j*64 +: 64] = acc_sum;
    end
  end

  logic [31:0] m_a [CW];
  logic [31:0] m_b [CW*CH];
  logic [63:0] m_c [CW];
  logic        m_done, m_err, m_ready;
  logic [31:0] m_rdata;
  int          m_left;

  task automatic chk(input string nm, input int idx, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s[%0d]: got %h expected %h", nm, idx, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < CW; i++) begin m_a[i] = 0; m_c[i] = 0; end
    for (int k = 0; k < CW*CH; k++) m_b[k] = 0;
    m_done = 0; m_err = 0; m_ready = 0; m_rdata = 0; m_left = 0;
  endtask

  function automatic logic [31:0] model_read(input int w);
    logic [31:0] r;
    r = 0;
    if (w == 1) r = {29'd0, m_err, m_done, (m_left > 0)};
    else if (w >= 'h40 && w < 'h40 + CW) r = m_a[w - 'h40];
    else if (w >= 'h80 && w < 'h80 + CW*CH) r = m_b[w - 'h80];
    else if (w >= 'h200 && w < 'h200 + 2*CW) begin
      if ((w - 'h200) % 2 == 0) r = m_c[(w - 'h200) / 2][31:0];
      else r = m_c[(w - 'h200) / 2][63:32];
    end
    return r;
  endfunction

  function automatic logic [31:0] bmerge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] s);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[b*8 +: 8] = s[b] ? n[b*8 +: 8] : o[b*8 +: 8];
    return r;
  endfunction

  task automatic model_step();
    logic acc, was_run, new_run;
    logic [63:0] s;
    int w;
    if (!resetn) begin model_reset(); return; end
    acc     = bus.sel && bus.mem_valid && !m_ready;
    w       = int'(bus.mem_addr[11:2]);
    was_run = (m_left > 0);
    new_run = 0;
    m_rdata = (acc && bus.mem_wstrb == 4'b0) ? model_read(w) : 32'h0;
    m_ready = acc;
    if (acc && bus.mem_wstrb != 4'b0) begin
      if (w == 0) begin
        if (bus.mem_wstrb[0]) begin
          if (bus.mem_wdata[2]) m_err = 0;
          if (bus.mem_wdata[1]) m_done = 0;
          if (bus.mem_wdata[0]) begin
            if (was_run) m_err = 1;
            else begin m_done = 0; new_run = 1; end
          end
        end
      end else if (w >= 'h40 && w < 'h40 + CW) begin
        if (was_run) m_err = 1;
        else m_a[w - 'h40] = bmerge(m_a[w - 'h40], bus.mem_wdata, bus.mem_wstrb);
      end else if (w >= 'h80 && w < 'h80 + CW*CH) begin
        if (was_run) m_err = 1;
        else m_b[w - 'h80] = bmerge(m_b[w - 'h80], bus.mem_wdata, bus.mem_wstrb);
      end
    end
    if (was_run) begin
      m_left--;
      if (m_left == 0) begin
        for (int j = 0; j < CH; j++) begin
          s = 0;
          for (int i = 0; i < CW; i++) s = s + 64'(m_a[i]) * 64'(m_b[i*CH+j]);
          m_c[j] = s;
        end
        m_done = 1;
      end
    end
    if (new_run) m_left = LAT;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge resetn);
      model_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      chk("mem_ready", 0, 64'(bus.mem_ready), 64'(m_ready));
      chk("mem_rdata", 0, 64'(bus.mem_rdata), 64'(m_rdata));
      chk("irq", 0, 64'(irq), 64'(m_done));
      for (int i = 0; i < CW; i++) chk("acc_row_a", i, 64'(acc_row_a[i*DW +: DW]), 64'(m_a[i]));
      for (int k = 0; k < CW*CH; k++) chk("acc_matrix_b", k, 64'(acc_matrix_b[k*DW +: DW]), 64'(m_b[k]));
    end
  end

  task automatic xfer(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s, output logic [31:0] r);
    bus.sel = 1; bus.mem_valid = 1; bus.mem_addr = a; bus.mem_wdata = d; bus.mem_wstrb = s;
    @(posedge clk); #3;
    chk("ready_after_valid", int'(a), 64'(bus.mem_ready), 64'd1);
    r = bus.mem_rdata;
    bus.sel = 0; bus.mem_valid = 0; bus.mem_wstrb = 0;
    @(posedge clk); #3;
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    logic [31:0] r;
    xfer(a, d, 4'hF, r);
  endtask

  task automatic rd_chk(input string nm, input logic [11:0] a, input logic [31:0] exp);
    logic [31:0] r;
    xfer(a, 32'h0, 4'h0, r);
    chk(nm, int'(a), 64'(r), 64'(exp));
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #3;
  endtask

  initial begin
    bus.sel = 0; bus.mem_valid = 0; bus.mem_addr = 0; bus.mem_wdata = 0; bus.mem_wstrb = 0;
    #1 resetn = 0;
    repeat (3) @(posedge clk);
    #3 resetn = 1;

    rd_chk("reset_status", 12'h004, 32'h0);
    chk("reset_irq", 0, 64'(irq), 64'd0);
    rd_chk("reset_row_c", 12'h800, 32'h0);
    chk("reset_acc_row_a", 0, 64'(|acc_row_a), 64'd0);

    for (int i = 0; i < CW; i++) wr(12'h100 + 12'(4*i), 32'(i + 1));
    for (int i = 0; i < CW; i++) wr(12'h200 + 12'(4*(i*CH + i)), 32'd1);
    wr(12'h000, 32'h1);
    rd_chk("ident_busy", 12'h004, 32'h1);
    idle(8);
    rd_chk("ident_done", 12'h004, 32'h2);
    chk("ident_irq", 0, 64'(irq), 64'd1);
    rd_chk("ident_c0_lo", 12'h800, 32'd1);
    rd_chk("ident_c3_lo", 12'h818, 32'd4);
    rd_chk("ident_c7_lo", 12'h838, 32'd8);
    rd_chk("ident_c7_hi", 12'h83C, 32'd0);

    wr(12'h100, 32'hFFFF_FFFF);
    for (int i = 1; i < CW; i++) wr(12'h100 + 12'(4*i), 32'h0);
    wr(12'h200, 32'hFFFF_FFFF);
    for (int i = 1; i < CW; i++) wr(12'h200 + 12'(4*(i*CH + i)), 32'h0);
    wr(12'h000, 32'h3);
    rd_chk("wide_start_clears_done", 12'h004, 32'h1);
    idle(8);
    rd_chk("wide_c0_lo", 12'h800, 32'h0000_0001);
    rd_chk("wide_c0_hi", 12'h804, 32'hFFFF_FFFE);
    rd_chk("wide_c1_lo", 12'h808, 32'h0);

    wr(12'h000, 32'h1);
    wr(12'h100, 32'd5);
    wr(12'h000, 32'h1);
    idle(8);
    rd_chk("busy_status", 12'h004, 32'h6);
    rd_chk("busy_row_a0", 12'h100, 32'hFFFF_FFFF);
    rd_chk("busy_c0_hi", 12'h804, 32'hFFFF_FFFE);
    wr(12'h000, 32'h4);
    rd_chk("clear_err", 12'h004, 32'h2);

    wr(12'h000, 32'h1);
    rd_chk("cap_busy", 12'h004, 32'h1);
    wr(12'h000, 32'h2);
    rd_chk("capture_beats_clear", 12'h004, 32'h2);

    wr(12'h10C, 32'hAABB_CCDD);
    begin
      logic [31:0] r;
      xfer(12'h10C, 32'h0000_1100, 4'b0010, r);
    end
    rd_chk("byte_strobe", 12'h10C, 32'hAABB_11DD);

    wr(12'h400, 32'h1234_5678);
    wr(12'h004, 32'h7);
    rd_chk("unmapped_read", 12'h400, 32'h0);
    rd_chk("ctrl_reads_zero", 12'h000, 32'h0);
    rd_chk("status_write_ignored", 12'h004, 32'h2);

    wr(12'h000, 32'h1);
    resetn = 0;
    @(posedge clk); #3;
    resetn = 1;
    idle(LAT + 4);
    rd_chk("rst_run_status", 12'h004, 32'h0);
    chk("rst_run_irq", 0, 64'(irq), 64'd0);
    rd_chk("rst_run_c0_lo", 12'h800, 32'h0);
    rd_chk("rst_run_c0_hi", 12'h804, 32'h0);

    idle(2);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mm_acc_ctrl.md
Name: mm_acc_ctrl

Overview:
Memory-mapped controller that sequences the combinational matmul accelerator from the PicoRV32 native memory bus. Software writes an operand row A and chunk matrix B into controller-owned registers, then issues START. The controller drives the accelerator, waits a fixed settle latency and captures row C into readable result registers. It sits as a bus slave beside the core, selected by the top-level address decoder.

Parameters:
DATA_WIDTH, 32, operand element width (bus is 32-bit; only 32 is supported)
CHUNK_WIDTH, 8, elements in row A / row C; rows of B
CHUNK_HEIGHT, 8, columns of B
ACC_LATENCY, 2, cycles (>=1) from operand freeze to result capture

Ports:
clk  in  1  system clock
resetn  in  1  asynchronous active-low reset
sel  in  1  address decoder hit for this block's 4 KiB window
mem_valid  in  1  core request valid
mem_ready  out  1  one-cycle acknowledge
mem_addr  in  12  byte offset within the window
mem_wdata  in  32  write data
mem_wstrb  in  4  byte write strobes; 0 = read
mem_rdata  out  32  read data, valid while mem_ready=1
acc_row_a  out  CHUNK_WIDTH*DATA_WIDTH  flattened row A, element i at [i*DW +: DW]
acc_matrix_b  out  CHUNK_WIDTH*CHUNK_HEIGHT*DATA_WIDTH  flattened B, element (i,j) at index i*CHUNK_HEIGHT+j
acc_row_c  in  CHUNK_WIDTH*2*DATA_WIDTH  flattened accelerator result
irq  out  1  level, equals STATUS.done

Behaviour:
- Reset (async, resetn=0): all operand/result registers 0, state IDLE, mem_ready=0, mem_rdata=0, done=0, err=0, irq=0.
- Register map (word offsets; low 2 address bits ignored):
  0x000 CTRL write: bit0 START, bit1 CLEAR_DONE, bit2 CLEAR_ERR (write-1 pulses); reads 0.
  0x004 STATUS read: bit0 busy, bit1 done, bit2 err; writes ignored.
  0x100+4i row_a[i], i<CHUNK_WIDTH.
  0x200+4k matrix_b element k=i*CHUNK_HEIGHT+j.
  0x800+8i row_c[i] low word, 0x804+8i high word; read-only.
  Unmapped offsets: reads 0, writes dropped, ack still given.
- Handshake: request accepted on cycle where sel&mem_valid&!mem_ready; mem_ready=1 exactly the next cycle, for one cycle; mem_rdata registered with it, 0 when not ready. Back-to-back request re-accepted the cycle after mem_ready drops.
- Writes honour mem_wstrb per byte on row_a/matrix_b; CTRL acts if wstrb[0]=1.
- FSM: IDLE -> (START) RUN; counter loads ACC_LATENCY-1, decrements each cycle; at 0 capture acc_row_c into row_c, set done, -> IDLE. busy=1 in RUN.
- START accepted in IDLE only; START while RUN ignored and sets err. START clears done on entry to RUN.
- Operand write while RUN: dropped, err set (operands frozen). Reads during RUN allowed; row_c returns previous result.
- CLEAR_DONE with START in same write: START wins, done=0.
- Capture cycle coinciding with CLEAR_DONE write: done ends 1 (capture wins).
- acc_row_a/acc_matrix_b driven directly from operand registers at all times.
- Result arithmetic is the accelerator's; controller stores 2*DATA_WIDTH bits unmodified.
- resetn low mid-RUN: immediate abort, all state to reset values, no capture.

Decomposition:
- Package mm_pkg: register offsets (CTRL, STATUS, ROW_A_BASE, MAT_B_BASE, ROW_C_BASE), STATUS bit indices, FSM state enum {IDLE, RUN}.
- One sub-module natural: mm_bus_slave (accept/ready/rdata registering, strobe merge), leaving FSM and storage in mm_acc_ctrl.

Test Plan:
- Reset: hold resetn=0 3 cycles -> STATUS reads 0, irq=0, row_c reads 0, acc_row_a all 0.
- Identity: row_a=1..8, B=I8, START -> busy 1 for ACC_LATENCY cycles, then done=1, irq=1, row_c[i] low=i+1, high=0.
- Wide product: row_a[0]=0xFFFFFFFF, B[0][0]=0xFFFFFFFF, rest 0 -> row_c[0] low=0x00000001, high=0xFFFFFFFE (accelerator unsigned).
- Busy protection: START, then write row_a[0]=5 and second START during RUN -> write dropped (readback old value), err=1, single capture; CLEAR_ERR -> err=0.
- Byte strobes: write row_a[3]=0xAABBCCDD then wstrb=0b0010 data 0x00001100 -> readback 0xAABB11DD; each access mem_ready exactly 1 cycle after valid.
- Reset mid-RUN: START then resetn=0 one cycle later -> busy=0, done=0, row_c stays 0 after release.
